// File: rtl/pll_lock_supervisor_if.sv
// ---------------------------------------------------------------------------
// pll_lock_supervisor_if
// Control/status bundle between the PLL lock supervisor and its environment.
//   restart        : request to re-run the bring-up sequence (to supervisor)
//   pll_locked     : raw PLL lock indicator, asynchronous (to supervisor)
//   pll_rst        : reset to the PLL, active-high (from supervisor)
//   sys_rst        : downstream system reset, active-high (from supervisor)
//   ready          : high while the supervisor is in RUN
//   fault          : high while the supervisor is in FAULT
//   state          : current state encoding, debug only
//   retry_cnt      : timed-out attempts in the current sequence
//   lock_loss_cnt  : losses of lock seen in RUN, saturating
// master = environment side, slave = supervisor side.
// ---------------------------------------------------------------------------
interface pll_lock_supervisor_if;
  logic       restart;
  logic       pll_locked;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic       fault;
  logic [2:0] state;
  logic [7:0] retry_cnt;
  logic [7:0] lock_loss_cnt;

  modport master (
    output restart, pll_locked,
    input  pll_rst, sys_rst, ready, fault, state, retry_cnt, lock_loss_cnt
  );

  modport slave (
    input  restart, pll_locked,
    output pll_rst, sys_rst, ready, fault, state, retry_cnt, lock_loss_cnt
  );
endinterface

// File: rtl/pll_lock_supervisor.sv
// ---------------------------------------------------------------------------
// pll_lock_supervisor
// Sequences reset/lock bring-up of a PLL. Holds the PLL in reset for a fixed
// number of cycles, waits (with timeout and bounded retries) for lock, requires
// lock to be stable for a programmable time, then releases the system reset.
// A loss of lock in RUN re-runs the whole sequence; repeated lock timeouts end
// in a terminal FAULT that only rst or restart leave.
// Ports:
//   refclk : free-running reference clock, sole clock
//   rst    : synchronous active-high reset
//   bus    : slave modport of pll_lock_supervisor_if (restart, pll_locked in;
//            pll_rst, sys_rst, ready, fault, state, retry_cnt,
//            lock_loss_cnt out)
// ---------------------------------------------------------------------------
module pll_lock_supervisor #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 3,
  parameter int CNT_W         = 20
) (
  input  logic                  refclk,
  input  logic                  rst,
  pll_lock_supervisor_if.slave  bus
);

  typedef enum logic [2:0] {
    S_RESET_PLL = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAULT     = 3'd4
  } state_t;

  // Terminal counts: each phase ends on the cycle the counter reaches N-1.
  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [7:0]       RETRY_MAX    = 8'(MAX_RETRIES);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_retry_cnt;
  logic [7:0]       r_lock_loss_cnt;
  logic             r_lock_meta;
  logic             r_lock_s;

  always_ff @(posedge refclk) begin
    if (rst) begin
      r_lock_meta     <= 1'b0;
      r_lock_s        <= 1'b0;
      r_state         <= S_RESET_PLL;
      r_cnt           <= '0;
      r_retry_cnt     <= '0;
      r_lock_loss_cnt <= '0;
    end else begin
      // Two-flop synchronizer for the asynchronous lock indicator.
      r_lock_meta <= bus.pll_locked;
      r_lock_s    <= r_lock_meta;

      if (bus.restart) begin
        // Restart keeps the lock-loss history; only rst clears it.
        r_state     <= S_RESET_PLL;
        r_cnt       <= '0;
        r_retry_cnt <= '0;
      end else begin
        case (r_state)
          S_RESET_PLL: begin
            if (r_cnt == RST_LAST) begin
              r_state <= S_WAIT_LOCK;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end

          S_WAIT_LOCK: begin
            // Lock on the timeout cycle takes precedence over the retry.
            if (r_lock_s) begin
              r_state <= S_STABLE;
              r_cnt   <= '0;
            end else if (r_cnt == TIMEOUT_LAST) begin
              if (r_retry_cnt == RETRY_MAX) begin
                r_state <= S_FAULT;
              end else begin
                r_retry_cnt <= r_retry_cnt + 1'b1;
                r_state     <= S_RESET_PLL;
                r_cnt       <= '0;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end

          S_STABLE: begin
            // A dropout here is a glitch, not a timeout: retry_cnt untouched.
            if (!r_lock_s) begin
              r_state <= S_WAIT_LOCK;
              r_cnt   <= '0;
            end else if (r_cnt == STABLE_LAST) begin
              r_state     <= S_RUN;
              r_retry_cnt <= '0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end

          S_RUN: begin
            if (!r_lock_s) begin
              r_state <= S_RESET_PLL;
              r_cnt   <= '0;
              if (r_lock_loss_cnt != 8'hFF) begin
                r_lock_loss_cnt <= r_lock_loss_cnt + 1'b1;
              end
            end
          end

          S_FAULT: begin
            r_state <= S_FAULT;
          end

          default: begin
            r_state <= S_RESET_PLL;
            r_cnt   <= '0;
          end
        endcase
      end
    end
  end

  // Moore decodes of the state register.
  assign bus.pll_rst       = (r_state == S_RESET_PLL) || (r_state == S_FAULT);
  assign bus.sys_rst       = (r_state != S_RUN);
  assign bus.ready         = (r_state == S_RUN);
  assign bus.fault         = (r_state == S_FAULT);
  assign bus.state         = r_state;
  assign bus.retry_cnt     = r_retry_cnt;
  assign bus.lock_loss_cnt = r_lock_loss_cnt;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// ---------------------------------------------------------------------------
// tb_pll_lock_supervisor
// Directed bring-up scenarios. Stimulus pushes cycle-tagged expected snapshots
// (state, retry_cnt, lock_loss_cnt) into a queue; an independent monitor pops
// them on the falling edge of the matching cycle and also flags any state
// change that no expectation accounts for.
// ---------------------------------------------------------------------------
module tb_pll_lock_supervisor;

  localparam logic [2:0] ST_RESET  = 3'd0;
  localparam logic [2:0] ST_WAIT   = 3'd1;
  localparam logic [2:0] ST_STABLE = 3'd2;
  localparam logic [2:0] ST_RUN    = 3'd3;
  localparam logic [2:0] ST_FAULT  = 3'd4;

  logic clk;
  logic rst;
  int   cyc;
  logic mon_en;
  int   checks;
  int   failures;

  logic [7:0] e_retry;
  logic [7:0] e_lls;

  typedef struct {
    int         cyc;
    logic [2:0] st;
    logic [7:0] retry;
    logic [7:0] lls;
    string      name;
  } exp_t;

  exp_t q[$];

  pll_lock_supervisor_if u_if ();

  pll_lock_supervisor #(
    .RST_CYCLES    (4),
    .LOCK_TIMEOUT  (32),
    .STABLE_CYCLES (8),
    .MAX_RETRIES   (2),
    .CNT_W         (20)
  ) u_dut (
    .refclk (clk),
    .rst    (rst),
    .bus    (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int c, input logic [2:0] s, input string name);
    exp_t e;
    e.cyc   = c;
    e.st    = s;
    e.retry = e_retry;
    e.lls   = e_lls;
    e.name  = name;
    q.push_back(e);
  endtask

  // Monitor / scoreboard
  logic [2:0] prev_state;
  exp_t       m_e;
  logic [3:0] m_exp_dec;
  logic [3:0] m_got_dec;
  logic       m_matched;

  always @(negedge clk) begin
    if (mon_en) begin
      m_matched = 1'b0;
      while (q.size() > 0 && q[0].cyc < cyc) begin
        m_e = q.pop_front();
        checks++;
        failures++;
        $display("FAIL %s: expectation for cycle %0d never evaluated (now %0d)", m_e.name, m_e.cyc, cyc);
      end
      while (q.size() > 0 && q[0].cyc == cyc) begin
        m_e = q.pop_front();
        m_matched = 1'b1;
        m_exp_dec = {(m_e.st == ST_RESET) || (m_e.st == ST_FAULT), m_e.st != ST_RUN,
                     m_e.st == ST_RUN, m_e.st == ST_FAULT};
        m_got_dec = {u_if.pll_rst, u_if.sys_rst, u_if.ready, u_if.fault};
        checks++;
        if (u_if.state !== m_e.st || u_if.retry_cnt !== m_e.retry ||
            u_if.lock_loss_cnt !== m_e.lls || m_got_dec !== m_exp_dec) begin
          failures++;
          $display("FAIL %s @cyc %0d: got state=%0d retry=%0d lls=%0d {pll_rst,sys_rst,ready,fault}=%b, required state=%0d retry=%0d lls=%0d %b",
                   m_e.name, cyc, u_if.state, u_if.retry_cnt, u_if.lock_loss_cnt, m_got_dec,
                   m_e.st, m_e.retry, m_e.lls, m_exp_dec);
        end
      end
      if (!m_matched && u_if.state !== prev_state) begin
        checks++;
        failures++;
        $display("FAIL unexpected_transition @cyc %0d: got state %0d -> %0d, required no change",
                 cyc, prev_state, u_if.state);
      end
    end
    prev_state = u_if.state;
  end

  // Watchdog: stimulus is open-loop, so this only guards a stuck simulator.
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  int d;
  int x;

  initial begin
    checks   = 0;
    failures = 0;
    mon_en   = 1'b0;
    rst      = 1'b1;
    u_if.restart    = 1'b0;
    u_if.pll_locked = 1'b0;
    e_retry  = 8'd0;
    e_lls    = 8'd0;

    tick(3);

    // 1: nominal bring-up; lock raised 10 cycles after reset release
    rst    = 1'b0;
    mon_en = 1'b1;
    d = cyc;
    push(d,      ST_RESET,  "t1_reset_state");
    push(d + 4,  ST_WAIT,   "t1_wait_lock");
    push(d + 13, ST_STABLE, "t1_stable");
    push(d + 21, ST_RUN,    "t1_run");
    tick(10);
    u_if.pll_locked = 1'b1;
    tick(13);

    // 2: glitch while STABLE cnt=4 (restart used to re-enter the sequence)
    d = cyc;
    u_if.restart = 1'b1;
    push(d + 1,  ST_RESET,  "t2_restart");
    push(d + 5,  ST_WAIT,   "t2_wait_lock");
    push(d + 6,  ST_STABLE, "t2_stable");
    push(d + 11, ST_WAIT,   "t2_glitch_back_to_wait");
    push(d + 14, ST_STABLE, "t2_relock");
    push(d + 22, ST_RUN,    "t2_run");
    tick(1);
    u_if.restart = 1'b0;
    tick(7);
    u_if.pll_locked = 1'b0;
    tick(3);
    u_if.pll_locked = 1'b1;
    tick(13);

    // 4: single-cycle lock loss in RUN, repeated until the counter saturates
    for (int i = 0; i < 260; i++) begin
      d = cyc;
      e_lls = (e_lls == 8'd255) ? 8'd255 : e_lls + 8'd1;
      push(d + 3,  ST_RESET,  "t4_loss_reset");
      push(d + 7,  ST_WAIT,   "t4_wait_lock");
      push(d + 8,  ST_STABLE, "t4_stable");
      push(d + 16, ST_RUN,    "t4_run");
      u_if.pll_locked = 1'b0;
      tick(1);
      u_if.pll_locked = 1'b1;
      tick(15);
    end

    // 3: lock never arrives -> three pll_rst pulses then FAULT
    d = cyc;
    u_if.pll_locked = 1'b0;
    u_if.restart    = 1'b1;
    e_retry = 8'd0;
    push(d + 1,   ST_RESET, "t3_pulse1");
    push(d + 5,   ST_WAIT,  "t3_wait1");
    e_retry = 8'd1;
    push(d + 37,  ST_RESET, "t3_pulse2");
    push(d + 41,  ST_WAIT,  "t3_wait2");
    e_retry = 8'd2;
    push(d + 73,  ST_RESET, "t3_pulse3");
    push(d + 77,  ST_WAIT,  "t3_wait3");
    push(d + 109, ST_FAULT, "t3_fault");
    push(d + 209, ST_FAULT, "t3_fault_held");
    tick(1);
    u_if.restart = 1'b0;
    tick(209);

    // 5a: restart out of FAULT, lock_loss_cnt kept
    d = cyc;
    u_if.restart    = 1'b1;
    u_if.pll_locked = 1'b1;
    e_retry = 8'd0;
    push(d + 1,  ST_RESET,  "t5_fault_cleared");
    push(d + 5,  ST_WAIT,   "t5_wait_lock");
    push(d + 6,  ST_STABLE, "t5_stable");
    push(d + 14, ST_RUN,    "t5_run_lls_kept");
    tick(1);
    u_if.restart = 1'b0;
    tick(15);

    // 5b: rst coincident with restart mid-STABLE clears everything
    d = cyc;
    u_if.restart = 1'b1;
    push(d + 1, ST_RESET,  "t5b_restart");
    push(d + 5, ST_WAIT,   "t5b_wait_lock");
    push(d + 6, ST_STABLE, "t5b_stable");
    tick(1);
    u_if.restart = 1'b0;
    tick(7);
    rst          = 1'b1;
    u_if.restart = 1'b1;
    e_lls   = 8'd0;
    e_retry = 8'd0;
    push(d + 9, ST_RESET, "t5b_rst_values");
    tick(1);
    u_if.restart = 1'b0;
    tick(1);
    rst = 1'b0;
    x = cyc;
    push(x + 4,  ST_WAIT,   "t5b_wait_after_rst");
    push(x + 5,  ST_STABLE, "t5b_stable_after_rst");
    push(x + 13, ST_RUN,    "t5b_run_after_rst");
    push(x + 20, ST_RUN,    "t5b_final");
    tick(21);

    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending expectations, required 0", q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
